// File: rtl/toggle_activity_monitor.sv
// Toggle / static-one activity monitor.
// Samples an observed vector over a programmable window and accumulates
// bit toggles between consecutive samples and the number of one bits.
// Totals are offered to the collector through a valid/ready result port.
module toggle_activity_monitor #(
    parameter int DATA_W = 5,
    parameter int CNT_W  = 16,
    parameter int WIN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIN_W-1:0]  window_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  toggle_cnt,
    output logic [CNT_W-1:0]  ones_cnt,
    output logic              saturated
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_COUNT  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    localparam logic [WIN_W-1:0] LEN_ZERO = {WIN_W{1'b0}};
    localparam logic [WIN_W-1:0] LEN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};

    // Number of one bits in a sample, zero-extended to accumulator width.
    function automatic logic [CNT_W-1:0] popcount(input logic [DATA_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < DATA_W; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Saturating add; result is {clipped, sum} and the sum never wraps.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[CNT_W]) begin
            s = {1'b1, {CNT_W{1'b1}}};
        end else begin
            s = s;
        end
        return s;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [WIN_W-1:0]   window_len_r, window_len_nxt_s;
    logic [WIN_W-1:0]   sample_cnt_r, sample_cnt_nxt_s, sample_inc_s;
    logic [DATA_W-1:0]  prev_r, prev_nxt_s;
    logic [CNT_W-1:0]   toggle_cnt_r, toggle_cnt_nxt_s;
    logic [CNT_W-1:0]   ones_cnt_r, ones_cnt_nxt_s;
    logic               saturated_r, saturated_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               res_valid_r, res_valid_nxt_s;
    logic [CNT_W:0]     toggle_add_s;
    logic [CNT_W:0]     ones_add_s;

    assign toggle_add_s = sat_add(toggle_cnt_r, popcount(in_data ^ prev_r));
    assign ones_add_s   = sat_add(ones_cnt_r, popcount(in_data));
    assign sample_inc_s = sample_cnt_r + LEN_ONE;

    // Next-state and next-accumulator logic for the window FSM.
    always_comb begin
        state_nxt_s      = state_r;
        window_len_nxt_s = window_len_r;
        sample_cnt_nxt_s = sample_cnt_r;
        prev_nxt_s       = prev_r;
        toggle_cnt_nxt_s = toggle_cnt_r;
        ones_cnt_nxt_s   = ones_cnt_r;
        saturated_nxt_s  = saturated_r;
        busy_nxt_s       = 1'b0;
        res_valid_nxt_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start && (window_len != LEN_ZERO)) begin
                    window_len_nxt_s = window_len;
                    sample_cnt_nxt_s = LEN_ZERO;
                    toggle_cnt_nxt_s = {CNT_W{1'b0}};
                    ones_cnt_nxt_s   = {CNT_W{1'b0}};
                    saturated_nxt_s  = 1'b0;
                    state_nxt_s      = ST_PRIME;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRIME: begin
                if (in_valid) begin
                    prev_nxt_s       = in_data;
                    ones_cnt_nxt_s   = ones_add_s[CNT_W-1:0];
                    saturated_nxt_s  = saturated_r | ones_add_s[CNT_W];
                    sample_cnt_nxt_s = LEN_ONE;
                    if (window_len_r == LEN_ONE) begin
                        state_nxt_s = ST_REPORT;
                    end else begin
                        state_nxt_s = ST_COUNT;
                    end
                end else begin
                    state_nxt_s = ST_PRIME;
                end
            end
            ST_COUNT: begin
                if (in_valid) begin
                    prev_nxt_s       = in_data;
                    toggle_cnt_nxt_s = toggle_add_s[CNT_W-1:0];
                    ones_cnt_nxt_s   = ones_add_s[CNT_W-1:0];
                    saturated_nxt_s  = saturated_r | toggle_add_s[CNT_W] | ones_add_s[CNT_W];
                    sample_cnt_nxt_s = sample_inc_s;
                    if (sample_inc_s == window_len_r) begin
                        state_nxt_s = ST_REPORT;
                    end else begin
                        state_nxt_s = ST_COUNT;
                    end
                end else begin
                    state_nxt_s = ST_COUNT;
                end
            end
            ST_REPORT: begin
                if (res_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REPORT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        if ((state_nxt_s == ST_PRIME) || (state_nxt_s == ST_COUNT)) begin
            busy_nxt_s = 1'b1;
        end else begin
            busy_nxt_s = 1'b0;
        end

        if (state_nxt_s == ST_REPORT) begin
            res_valid_nxt_s = 1'b1;
        end else begin
            res_valid_nxt_s = 1'b0;
        end
    end

    // State, accumulator and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            window_len_r <= LEN_ZERO;
            sample_cnt_r <= LEN_ZERO;
            prev_r       <= {DATA_W{1'b0}};
            toggle_cnt_r <= {CNT_W{1'b0}};
            ones_cnt_r   <= {CNT_W{1'b0}};
            saturated_r  <= 1'b0;
            busy_r       <= 1'b0;
            res_valid_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            window_len_r <= window_len_nxt_s;
            sample_cnt_r <= sample_cnt_nxt_s;
            prev_r       <= prev_nxt_s;
            toggle_cnt_r <= toggle_cnt_nxt_s;
            ones_cnt_r   <= ones_cnt_nxt_s;
            saturated_r  <= saturated_nxt_s;
            busy_r       <= busy_nxt_s;
            res_valid_r  <= res_valid_nxt_s;
        end
    end

    assign busy       = busy_r;
    assign res_valid  = res_valid_r;
    assign toggle_cnt = toggle_cnt_r;
    assign ones_cnt   = ones_cnt_r;
    assign saturated  = saturated_r;

endmodule
